// File: rtl/tile_draw_ctrl.sv
// Falling-tile game sequencer: owns the tile's lane/offset, scroll timing and
// hit/miss scoring, and sequences the lane-erase and block drawers per scroll step.
module tile_draw_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter int OFFSET_MAX = 39,
  parameter int HIT_MIN    = 20,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               startn,
  input  logic               frame_tick,
  input  logic [3:0]         key_hit,
  input  logic               colour_line_done,
  input  logic               colour_block_done,
  output logic [2:0]         line_id,
  output logic [5:0]         offset,
  output logic               colour_line_go,
  output logic               colour_block_go,
  output logic               plot,
  output logic [2:0]         colour,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over,
  output logic [4:0]         current_st
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT      = 3'd1,
    S_CHECK     = 3'd2,
    S_CLEAR     = 3'd3,
    S_CLEAR_GAP = 3'd4,
    S_DRAW      = 3'd5,
    S_DRAW_GAP  = 3'd6,
    S_OVER      = 3'd7
  } state_e;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [5:0]    OFF_MAX   = 6'(OFFSET_MAX);
  localparam logic [5:0]    HIT_OFF   = 6'(HIT_MIN);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  state_e             state_q, state_d;
  logic [2:0]         lane_q, lane_d;
  logic [2:0]         old_lane_q, old_lane_d;
  logic [5:0]         offset_q, offset_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               hit_q, hit_d;
  logic [3:0]         lfsr_q, lfsr_d;

  logic [2:0] spawn_lane;
  logic [1:0] key_idx;

  assign lfsr_d     = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign spawn_lane = {1'b0, lfsr_q[1:0]} + 3'd1;

  // The erase pass addresses the lane the tile just left; everything else uses the live lane.
  assign line_id = (state_q == S_CLEAR) ? old_lane_q : lane_q;
  assign key_idx = line_id[1:0] - 2'd1;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    old_lane_d = old_lane_q;
    offset_d   = offset_q;
    score_d    = score_q;
    lives_d    = lives_q;
    tick_d     = tick_q;
    hit_d      = hit_q;

    if (state_q == S_CHECK)
      hit_d = 1'b0;
    else if (state_q != S_IDLE && state_q != S_OVER && key_hit[key_idx])
      hit_d = 1'b1;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (!startn) begin
          lane_d     = spawn_lane;
          old_lane_d = spawn_lane;
          offset_d   = 6'd0;
          score_d    = '0;
          lives_d    = LIVES_INIT;
          state_d    = S_CLEAR;
        end
      end
      S_WAIT: begin
        if (frame_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = S_CHECK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_CHECK: begin
        state_d    = S_CLEAR;
        old_lane_d = lane_q;
        if (hit_q && offset_q >= HIT_OFF) begin
          if (score_q != '1) score_d = score_q + 1'b1;
          lane_d   = spawn_lane;
          offset_d = 6'd0;
        end else if (offset_q == OFF_MAX) begin
          if (lives_q == 2'd1) begin
            lives_d    = 2'd0;
            old_lane_d = old_lane_q;
            state_d    = S_OVER;
          end else begin
            lives_d  = lives_q - 2'd1;
            lane_d   = spawn_lane;
            offset_d = 6'd0;
          end
        end else begin
          offset_d = offset_q + 6'd1;
        end
      end
      S_CLEAR:     if (colour_line_done)  state_d = S_CLEAR_GAP;
      S_CLEAR_GAP: state_d = S_DRAW;
      S_DRAW:      if (colour_block_done) state_d = S_DRAW_GAP;
      S_DRAW_GAP:  state_d = S_WAIT;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lane_q     <= 3'd1;
      old_lane_q <= 3'd1;
      offset_q   <= 6'd0;
      score_q    <= '0;
      lives_q    <= LIVES_INIT;
      tick_q     <= '0;
      hit_q      <= 1'b0;
      lfsr_q     <= 4'b1001;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      old_lane_q <= old_lane_d;
      offset_q   <= offset_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      tick_q     <= tick_d;
      hit_q      <= hit_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Go strobes are decoded from state so a reset drops them on the same edge.
  assign colour_line_go  = (state_q == S_CLEAR);
  assign colour_block_go = (state_q == S_DRAW);
  assign plot   = (colour_line_go & ~colour_line_done) | (colour_block_go & ~colour_block_done);
  assign colour = (state_q == S_DRAW) ? 3'b000 : 3'b111;
  assign offset     = offset_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == S_OVER);
  assign current_st = {2'b00, state_q};

endmodule

// File: doc/tile_draw_ctrl.md
Name: tile_draw_ctrl

Overview:
Game-sequencing FSM sitting directly upstream of the lane-erase and tile-block pixel drawers. Owns the single falling tile: its lane, its vertical offset, scroll timing, and hit/miss scoring from the lane keys. On every scroll step it erases the tile's old lane and then redraws the block, driving both drawers through go/done handshakes. It exports the pixel colour and plot strobe used by the VGA write mux.

Parameters:
TICK_DIV, 4, frame_tick pulses per one-row scroll step (>=1)
OFFSET_MAX, 39, last legal offset; the tile region is rows 200+offset..239
HIT_MIN, 20, minimum offset at which a key press scores
LIVES, 3, misses allowed before game over (1..3)
SCORE_W, 8, score counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
startn  in  1  active-low start/restart request (level, sampled each cycle)
frame_tick  in  1  one-cycle pulse per video frame
key_hit  in  4  one-cycle key pulses; bit k = lane k+1
colour_line_done  in  1  lane-erase drawer finished
colour_block_done  in  1  block drawer finished
line_id  out  3  lane to draw, 1..4
offset  out  6  tile offset, 0..OFFSET_MAX
colour_line_go  out  1  request lane erase
colour_block_go  out  1  request block draw
plot  out  1  VGA write enable
colour  out  3  pixel colour
score  out  SCORE_W  hits, saturating
lives  out  2  remaining lives
game_over  out  1  high in OVER state
current_st  out  5  state code (zero-extended)

Behaviour:
- Reset (reset==0 at clock edge): state IDLE; offset=0, line_id=1, old_lane=1, both go=0, plot=0, colour=3'b111, score=0, lives=LIVES, game_over=0, tick_cnt=0, hit_pending=0, lfsr=4'b1001.
- States/codes: IDLE=0, WAIT=1, CHECK=2, CLEAR=3, CLEAR_GAP=4, DRAW=5, DRAW_GAP=6, OVER=7.
- LFSR: 4-bit Fibonacci over x^4+x^3+1; advances every non-reset cycle in all states. The spawned lane is lfsr[1:0]+1, sampled at the spawn edge.
- IDLE: when startn==0, spawn a tile (lane from LFSR, offset=0, old_lane=new lane), score=0, lives=LIVES, then go to CLEAR.
- CLEAR: line_id=old_lane, colour_line_go=1, colour=3'b111 (background). When colour_line_done==1, go to CLEAR_GAP.
- CLEAR_GAP: both go=0 for exactly one cycle so the drawer rearms, then go to DRAW.
- DRAW: line_id=current lane, colour_block_go=1, colour=3'b000 (tile). When colour_block_done==1, go to DRAW_GAP.
- DRAW_GAP: one cycle with go=0, then go to WAIT.
- plot = (colour_line_go & !colour_line_done) | (colour_block_go & !colour_block_done). No other state asserts plot.
- WAIT: each frame_tick increments tick_cnt. On the tick where tick_cnt==TICK_DIV-1, clear tick_cnt and go to CHECK. Ticks arriving in any other state are dropped.
- hit_pending: set in any state except IDLE/OVER when key_hit[line_id-1]==1. Presses on other lanes are ignored. Cleared in CHECK.
- CHECK evaluates exactly one of the following, in priority order:
  1. hit_pending && offset>=HIT_MIN: score+1 (saturates at all-ones); old_lane=lane; spawn a new tile.
  2. offset==OFFSET_MAX: miss. If lives==1: lives=0 and go to OVER. Otherwise lives-1, old_lane=lane, spawn a new tile.
  3. Otherwise: old_lane=lane, offset+1.
  - Cases 1–3 then go to CLEAR.
  - A hit with offset<HIT_MIN is discarded with no penalty.
- OVER: game_over=1, go signals low. When startn==0, behave as IDLE start in that same cycle.
- A done signal arriving outside its waiting state is ignored.
- startn is ignored outside IDLE/OVER.
- reset==0 mid-draw returns to the reset values at the next edge; go drops immediately.
- Per-step latency: CHECK(1) + CLEAR(N_line) + 1 + DRAW(N_block) + 1 cycles before re-entering WAIT.

Test Plan:
- Reset, then startn low 1 cycle with lfsr=4'b1001 -> state 0→3; line_id=2, offset=0, colour_line_go=1, colour=7.
- Pulse colour_line_done, then colour_block_done -> exactly 1 gap cycle with both go=0 after each; state reaches 1; plot high only while go=1 and done=0.
- TICK_DIV=4, 8 frame_ticks in WAIT (drawer bench auto-completes) -> offset 0→2; a tick during DRAW does not count.
- Advance to offset=25 in lane 3, pulse key_hit=4'b0100 -> next CHECK gives score=1, new spawn with offset=0, erase of lane 3; key_hit=4'b0001 gives no score.
- Press the correct key at offset=5 -> score unchanged, offset advances to 6, lives unchanged.
- No keys, 3 tiles reach offset 39 -> lives 3→2→1→0, game_over=1, state 7; startn low restarts with score=0, lives=3.
